// File: rtl/data_modulate_pkg.sv
// Shared definitions for the KxK window modulator: FSM states, the
// half-window helper and the zero value used for all border padding.
package data_modulate_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Pixel value injected for out-of-image taps.
  localparam int PAD_PIX = 0;

  // Number of taps on each side of the window centre.
  function automatic int half_win(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/dm_shift_window.sv
// KxK tap register array. Each shift moves every tap one column to the
// left and loads a new column into the rightmost column; clear zeroes all.
module dm_shift_window
  import data_modulate_pkg::*;
#(
  parameter int K  = 5,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                shift_en,
  input  logic [K*DW-1:0]     col,
  output logic [K*K*DW-1:0]   win
);

  localparam logic [DW-1:0] PAD = DW'(PAD_PIX);

  // Shift the window left by one column, clear has priority over shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
    end else if (clr) begin
      win <= {K*K{PAD}};
    end else if (shift_en) begin
      for (int kr = 0; kr < K; kr++) begin
        for (int j = 0; j < K - 1; j++) begin
          win[(kr*K+j)*DW +: DW] <= win[(kr*K+j+1)*DW +: DW];
        end
        win[(kr*K+K-1)*DW +: DW] <= col[kr*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/data_modulate_kxk.sv
// KxK sliding-window generator over a ROWSxCOLS image fed column by column.
// Borders are zero padded. Optional status ports (frame counter, overrun
// flag) are built only when DATA_MODULATE_STATUS_EN is defined.
module data_modulate_kxk
  import data_modulate_pkg::*;
#(
  parameter int K    = 5,
  parameter int DW   = 8,
  parameter int ROWS = 7,
  parameter int COLS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [K*DW-1:0]     col_i,
  input  logic                col_valid_i,
  output logic                col_ready_o,
  output logic [K*K*DW-1:0]   win_o,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic                done_o
`ifdef DATA_MODULATE_STATUS_EN
  ,
  output logic [15:0]         frame_cnt_o,
  output logic                overrun_o
`endif
);

  localparam int H  = half_win(K);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] H_C      = CW'(H);
  localparam logic [CW-1:0] H_M1     = CW'(H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0] PAD      = DW'(PAD_PIX);

  state_t            state;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              out_free;
  logic              col_accept;
  logic              flush_shift;
  logic              flush_end;
  logic              start_take;
  logic              win_clr;
  logic              shift_en;
  logic [K*DW-1:0]   col_masked;
  logic [K*DW-1:0]   shift_col;

  // Handshake qualifiers derived from the current state
  always_comb begin
    out_free    = !win_valid_o || win_ready_i;
    col_ready_o = ((state == FILL) || (state == RUN)) && out_free;
    col_accept  = col_valid_i && col_ready_o;
    flush_shift = (state == FLUSH) && (col_cnt < H_C) && out_free;
    flush_end   = (state == FLUSH) && (col_cnt == H_C) && win_valid_o && win_ready_i;
    start_take  = ((state == IDLE) || (state == DONE)) && start_i;
    win_clr     = start_take || flush_end;
    shift_en    = col_accept || flush_shift;
  end

  // Zero the taps of rows that fall above or below the image
  always_comb begin
    col_masked = col_i;
    for (int k = 0; k < K; k++) begin
      if ((int'(row_cnt) + k - H < 0) || (int'(row_cnt) + k - H > ROWS - 1)) begin
        col_masked[k*DW +: DW] = PAD;
      end
    end
    shift_col = col_accept ? col_masked : {K{PAD}};
  end

  dm_shift_window #(
    .K  (K),
    .DW (DW)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (win_clr),
    .shift_en (shift_en),
    .col      (shift_col),
    .win      (win_o)
  );

  // Frame sequencing: fill, run and flush each row, then report done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col_cnt     <= '0;
      row_cnt     <= '0;
      win_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      if (win_valid_o && win_ready_i) begin
        win_valid_o <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state   <= FILL;
            col_cnt <= '0;
            row_cnt <= '0;
            done_o  <= 1'b0;
          end
        end
        FILL: begin
          if (col_accept) begin
            col_cnt <= col_cnt + CW'(1);
            if (col_cnt == H_M1) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (col_accept) begin
            win_valid_o <= 1'b1;
            if (col_cnt == COL_LAST) begin
              state   <= FLUSH;
              col_cnt <= '0;
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_shift) begin
            win_valid_o <= 1'b1;
            col_cnt     <= col_cnt + CW'(1);
          end else if (flush_end) begin
            col_cnt <= '0;
            if (row_cnt == ROW_LAST) begin
              state   <= DONE;
              done_o  <= 1'b1;
              row_cnt <= '0;
            end else begin
              state   <= FILL;
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_MODULATE_STATUS_EN
  // Completed-frame counter and sticky overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_o <= '0;
      overrun_o   <= 1'b0;
    end else begin
      if (flush_end && (row_cnt == ROW_LAST)) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (start_take) begin
        overrun_o <= 1'b0;
      end else if (col_valid_i && !col_ready_o && ((state == FLUSH) || (state == DONE))) begin
        overrun_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_modulate_kxk.sv
// Bench for data_modulate_kxk: three instances (K=3 5x5, K=5 7x7, K=7 9x9)
// share one driver selected by 'sel'. Status checks need DATA_MODULATE_STATUS_EN.
module tb_data_modulate_kxk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        start_drv;
  logic        col_valid_drv;
  logic        win_ready_drv;
  logic [55:0] col_drv;

  logic        start0, cv0, cr0, wv0, wr0, dn0;
  logic [23:0] col0;
  logic [71:0] win0;
  logic        start1, cv1, cr1, wv1, wr1, dn1;
  logic [39:0] col1;
  logic [199:0] win1;
  logic        start2, cv2, cr2, wv2, wr2, dn2;
  logic [55:0] col2;
  logic [391:0] win2;
`ifdef DATA_MODULATE_STATUS_EN
  logic [15:0] fcnt0, fcnt1, fcnt2;
  logic        ovr0, ovr1, ovr2;
`endif

  logic         col_ready_m, win_valid_m, done_m;
  logic [391:0] win_m;

  assign start0 = start_drv && (sel == 0);
  assign cv0    = col_valid_drv && (sel == 0);
  assign wr0    = win_ready_drv && (sel == 0);
  assign col0   = col_drv[23:0];
  assign start1 = start_drv && (sel == 1);
  assign cv1    = col_valid_drv && (sel == 1);
  assign wr1    = win_ready_drv && (sel == 1);
  assign col1   = col_drv[39:0];
  assign start2 = start_drv && (sel == 2);
  assign cv2    = col_valid_drv && (sel == 2);
  assign wr2    = win_ready_drv && (sel == 2);
  assign col2   = col_drv;

  always_comb begin
    col_ready_m = cr0;
    win_valid_m = wv0;
    done_m      = dn0;
    win_m       = 392'(win0);
    case (sel)
      1: begin
        col_ready_m = cr1;
        win_valid_m = wv1;
        done_m      = dn1;
        win_m       = 392'(win1);
      end
      2: begin
        col_ready_m = cr2;
        win_valid_m = wv2;
        done_m      = dn2;
        win_m       = win2;
      end
      default: ;
    endcase
  end

  data_modulate_kxk #(.K(3), .DW(8), .ROWS(5), .COLS(5)) dut0 (
    .clk(clk), .rst(rst), .start_i(start0), .col_i(col0), .col_valid_i(cv0),
    .col_ready_o(cr0), .win_o(win0), .win_valid_o(wv0), .win_ready_i(wr0), .done_o(dn0)
`ifdef DATA_MODULATE_STATUS_EN
    , .frame_cnt_o(fcnt0), .overrun_o(ovr0)
`endif
  );

  data_modulate_kxk #(.K(5), .DW(8), .ROWS(7), .COLS(7)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .col_i(col1), .col_valid_i(cv1),
    .col_ready_o(cr1), .win_o(win1), .win_valid_o(wv1), .win_ready_i(wr1), .done_o(dn1)
`ifdef DATA_MODULATE_STATUS_EN
    , .frame_cnt_o(fcnt1), .overrun_o(ovr1)
`endif
  );

  data_modulate_kxk #(.K(7), .DW(8), .ROWS(9), .COLS(9)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .col_i(col2), .col_valid_i(cv2),
    .col_ready_o(cr2), .win_o(win2), .win_valid_o(wv2), .win_ready_i(wr2), .done_o(dn2)
`ifdef DATA_MODULATE_STATUS_EN
    , .frame_cnt_o(fcnt2), .overrun_o(ovr2)
`endif
  );

  int total = 0;
  int bad   = 0;

  int kk_t[3]   = '{3, 5, 7};
  int rows_t[3] = '{5, 7, 9};
  int cols_t[3] = '{5, 7, 9};

  logic [391:0] got_q[$];
  int   stall_cycles;
  int   stall_bad;
  int   timed_out;
  int   post_rst_wins;
  logic rst_win_valid, rst_done, rst_ready, rst_win_zero;

  // Image content for pattern 0 (ramp), 1 (all 0xFF) and 2 (scrambled)
  function automatic logic [7:0] pix(input int pat, input int r, input int c, input int cols);
    case (pat)
      0:       return 8'(r * cols + c);
      1:       return 8'hFF;
      default: return 8'(r * 37 + c * 11 + 3);
    endcase
  endfunction

  // Expected window centred on (r,c) with zero padding outside the image
  function automatic logic [391:0] exp_win(input int pat, input int k, input int rows,
                                           input int cols, input int r, input int c);
    logic [391:0] w;
    int h;
    w = '0;
    h = (k - 1) / 2;
    for (int kr = 0; kr < k; kr++) begin
      for (int j = 0; j < k; j++) begin
        if ((r + kr - h >= 0) && (r + kr - h < rows) && (c + j - h >= 0) && (c + j - h < cols))
          w[(kr*k+j)*8 +: 8] = pix(pat, r + kr - h, c + j - h, cols);
      end
    end
    return w;
  endfunction

  // Column vector for row r, column c; out-of-image rows carry junk 0xA5
  function automatic logic [55:0] col_data(input int pat, input int k, input int rows,
                                           input int cols, input int r, input int c);
    logic [55:0] d;
    int h;
    d = '0;
    h = (k - 1) / 2;
    for (int kr = 0; kr < k; kr++) begin
      if ((r + kr - h >= 0) && (r + kr - h < rows)) d[kr*8 +: 8] = pix(pat, r + kr - h, c, cols);
      else d[kr*8 +: 8] = 8'hA5;
    end
    return d;
  endfunction

  // Drive one frame into the selected instance and capture accepted windows
  task automatic applyStimulus(input int s, input int pat, input int gap, input int stall_at,
                               input int stall_len, input int rst_at, input bit hold_valid);
    int k, rows, cols, fr, fc, scnt;
    bit prev_stall, finished;
    logic [391:0] prev_win;
    k = kk_t[s]; rows = rows_t[s]; cols = cols_t[s];
    sel = s;
    got_q.delete();
    stall_cycles = 0; stall_bad = 0; timed_out = 0;
    fr = 0; fc = 0; scnt = 0; prev_stall = 0; finished = 0; prev_win = '0;
    @(negedge clk);
    start_drv = 1'b1; col_valid_drv = 1'b0; win_ready_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done_m) begin
        finished = 1;
        break;
      end
      if (rst_at >= 0 && got_q.size() == rst_at) begin
        rst = 1'b0; col_valid_drv = 1'b0;
        #1;
        rst_win_valid = win_valid_m; rst_done = done_m; rst_ready = col_ready_m;
        rst_win_zero  = (win_m == '0);
        @(negedge clk);
        rst = 1'b1; col_valid_drv = 1'b1; win_ready_drv = 1'b1;
        col_drv = col_data(pat, k, rows, cols, 0, 0);
        post_rst_wins = 0;
        repeat (6) begin
          @(negedge clk);
          if (win_valid_m) post_rst_wins++;
        end
        col_valid_drv = 1'b0;
        return;
      end
      if (stall_at >= 0 && got_q.size() == stall_at && win_valid_m && scnt < stall_len) begin
        win_ready_drv = 1'b0;
        scnt++;
      end else begin
        win_ready_drv = (gap != 0) ? ($urandom_range(1, 0) == 1) : 1'b1;
      end
      if (fr < rows) begin
        col_valid_drv = (gap != 0) ? ($urandom_range(1, 0) == 1) : 1'b1;
        col_drv = col_data(pat, k, rows, cols, fr, fc);
      end else begin
        col_valid_drv = hold_valid;
        col_drv = '0;
      end
      #1;
      if (win_valid_m && !win_ready_drv) begin
        stall_cycles++;
        if (col_ready_m) stall_bad++;
        if (prev_stall && (win_m !== prev_win)) stall_bad++;
        prev_stall = 1;
        prev_win = win_m;
      end else begin
        prev_stall = 0;
      end
      if (win_valid_m && win_ready_drv) got_q.push_back(win_m);
      if (col_valid_drv && col_ready_m) begin
        fc++;
        if (fc == cols) begin
          fc = 0;
          fr++;
        end
      end
      @(negedge clk);
    end
    if (!finished) timed_out = 1;
    col_valid_drv = 1'b0;
    win_ready_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_drv = 1'b0; col_valid_drv = 1'b0; win_ready_drv = 1'b0; col_drv = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total++;
      if (win_valid_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_win_valid dut%0d: got %b want 0", s, win_valid_m); end
      total++;
      if (done_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_done dut%0d: got %b want 0", s, done_m); end
      total++;
      if (col_ready_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_col_ready dut%0d: got %b want 0", s, col_ready_m); end
      total++;
      if (win_m !== '0) begin bad++; $display("[TB] FAIL reset_win dut%0d: got %h want 0", s, win_m); end
    end
    @(negedge clk);
    rst = 1'b1;
    sel = 1;
    @(negedge clk);
    col_valid_drv = 1'b1;
    #1;
    total++;
    if (col_ready_m !== 1'b0) begin bad++; $display("[TB] FAIL idle_col_ready: got %b want 0", col_ready_m); end
    col_valid_drv = 1'b0;
  endtask

  task automatic test_ramp_k3();
    logic [391:0] w00, w44, w;
    w00 = '0; w00[5*8 +: 8] = 8'd1; w00[7*8 +: 8] = 8'd5; w00[8*8 +: 8] = 8'd6;
    w44 = '0; w44[0 +: 8] = 8'd18; w44[8 +: 8] = 8'd19; w44[3*8 +: 8] = 8'd23; w44[4*8 +: 8] = 8'd24;
    applyStimulus(0, 0, 0, -1, -1, -1, 0);
    total++;
    if (timed_out !== 0) begin bad++; $display("[TB] FAIL ramp_timeout: got %0d want 0", timed_out); end
    total++;
    if (got_q.size() != 25) begin bad++; $display("[TB] FAIL ramp_count: got %0d want 25", got_q.size()); end
    if (got_q.size() == 25) begin
      w = got_q[0];
      total++;
      if (w !== w00) begin bad++; $display("[TB] FAIL ramp_win00: got %h want %h", w[71:0], w00[71:0]); end
      w = got_q[24];
      total++;
      if (w !== w44) begin bad++; $display("[TB] FAIL ramp_win44: got %h want %h", w[71:0], w44[71:0]); end
    end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_win(0, 3, 5, 5, i / 5, i % 5)) begin
        bad++;
        $display("[TB] FAIL ramp_win%0d: got %h want %h", i, got_q[i][71:0], exp_win(0, 3, 5, 5, i / 5, i % 5));
      end
    end
    total++;
    if (done_m !== 1'b1) begin bad++; $display("[TB] FAIL ramp_done: got %b want 1", done_m); end
    repeat (3) @(negedge clk);
    total++;
    if (done_m !== 1'b1) begin bad++; $display("[TB] FAIL ramp_done_hold: got %b want 1", done_m); end
  endtask

  task automatic test_ff_k5();
    logic [391:0] w;
    int n;
    applyStimulus(1, 1, 0, -1, -1, -1, 0);
    total++;
    if (got_q.size() != 49) begin bad++; $display("[TB] FAIL ff_count: got %0d want 49", got_q.size()); end
    if (got_q.size() == 49) begin
      w = got_q[0]; n = 0;
      for (int t = 0; t < 25; t++) if (w[t*8 +: 8] != 8'h00) n++;
      total++;
      if (n != 9) begin bad++; $display("[TB] FAIL ff_corner_taps: got %0d want 9", n); end
      w = got_q[24]; n = 0;
      for (int t = 0; t < 25; t++) if (w[t*8 +: 8] != 8'h00) n++;
      total++;
      if (n != 25) begin bad++; $display("[TB] FAIL ff_centre_taps: got %0d want 25", n); end
      w = got_q[48]; n = 0;
      for (int t = 0; t < 25; t++) if (w[t*8 +: 8] != 8'h00) n++;
      total++;
      if (n != 9) begin bad++; $display("[TB] FAIL ff_last_corner_taps: got %0d want 9", n); end
    end
    total++;
    if (done_m !== 1'b1) begin bad++; $display("[TB] FAIL ff_done: got %b want 1", done_m); end
  endtask

  task automatic test_stall_k5();
    applyStimulus(1, 2, 0, 10, 4, -1, 0);
    total++;
    if (stall_cycles != 4) begin bad++; $display("[TB] FAIL stall_cycles: got %0d want 4", stall_cycles); end
    total++;
    if (stall_bad != 0) begin bad++; $display("[TB] FAIL stall_hold: got %0d violations want 0", stall_bad); end
    total++;
    if (got_q.size() != 49) begin bad++; $display("[TB] FAIL stall_count: got %0d want 49", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_win(2, 5, 7, 7, i / 7, i % 7)) begin
        bad++;
        $display("[TB] FAIL stall_win%0d: got %h want %h", i, got_q[i][199:0], exp_win(2, 5, 7, 7, i / 7, i % 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1, 2, 0, -1, -1, 20, 0);
    total++;
    if (rst_win_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_win_valid: got %b want 0", rst_win_valid); end
    total++;
    if (rst_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_done: got %b want 0", rst_done); end
    total++;
    if (rst_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_col_ready: got %b want 0", rst_ready); end
    total++;
    if (rst_win_zero !== 1'b1) begin bad++; $display("[TB] FAIL midrst_win_zero: got %b want 1", rst_win_zero); end
    total++;
    if (post_rst_wins != 0) begin bad++; $display("[TB] FAIL midrst_no_output: got %0d windows want 0", post_rst_wins); end
    applyStimulus(1, 2, 0, -1, -1, -1, 0);
    total++;
    if (got_q.size() != 49) begin bad++; $display("[TB] FAIL midrst_count: got %0d want 49", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_win(2, 5, 7, 7, i / 7, i % 7)) begin
        bad++;
        $display("[TB] FAIL midrst_win%0d: got %h want %h", i, got_q[i][199:0], exp_win(2, 5, 7, 7, i / 7, i % 7));
      end
    end
  endtask

  task automatic test_random_k7();
    applyStimulus(2, 2, 1, -1, -1, -1, 0);
    total++;
    if (timed_out !== 0) begin bad++; $display("[TB] FAIL rand_timeout: got %0d want 0", timed_out); end
    total++;
    if (got_q.size() != 81) begin bad++; $display("[TB] FAIL rand_count: got %0d want 81", got_q.size()); end
    total++;
    if (stall_bad != 0) begin bad++; $display("[TB] FAIL rand_hold: got %0d violations want 0", stall_bad); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_win(2, 7, 9, 9, i / 9, i % 9)) begin
        bad++;
        $display("[TB] FAIL rand_win%0d: got %h want %h", i, got_q[i], exp_win(2, 7, 9, 9, i / 9, i % 9));
      end
    end
  endtask

`ifdef DATA_MODULATE_STATUS_EN
  task automatic test_status();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 2, 0, -1, -1, -1, 1);
    total++;
    if (ovr1 !== 1'b1) begin bad++; $display("[TB] FAIL status_overrun_set: got %b want 1", ovr1); end
    applyStimulus(1, 2, 0, -1, -1, -1, 0);
    total++;
    if (fcnt1 !== 16'd2) begin bad++; $display("[TB] FAIL status_frame_cnt: got %0d want 2", fcnt1); end
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    #1;
    total++;
    if (ovr1 !== 1'b0) begin bad++; $display("[TB] FAIL status_overrun_clear: got %b want 0", ovr1); end
  endtask
`endif

  initial begin
    sel = 1;
    test_reset();
    test_ramp_k3();
    test_ff_k5();
    test_stall_k5();
    test_reset_mid();
    test_random_k7();
`ifdef DATA_MODULATE_STATUS_EN
    test_status();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
